// File: rtl/hash_msg_sender_if.sv
// Signal bundle between the hash message sender and its upstream byte source,
// the hash core, and the downstream digest consumer.
interface hash_msg_sender_if #(
  parameter int LEN_W = 64
);
  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_ready;
  logic             M_valid;
  logic [7:0]       message;
  logic [LEN_W-1:0] counter;
  logic [31:0]      digest_in;
  logic             hash_ready;
  logic             d_valid;
  logic [31:0]      d_data;
  logic             d_ready;
  logic             busy;
  logic             timeout_err;

  modport master (
    input  start, msg_len, s_valid, s_data, digest_in, hash_ready, d_ready,
    output s_ready, M_valid, message, counter, d_valid, d_data, busy, timeout_err
  );

  modport slave (
    output start, msg_len, s_valid, s_data, digest_in, hash_ready, d_ready,
    input  s_ready, M_valid, message, counter, d_valid, d_data, busy, timeout_err
  );
endinterface

// File: rtl/hash_msg_sender.sv
// Feeds a length-prefixed byte stream to the hash core one byte at a time and
// hands the resulting 32-bit digest downstream on a valid/ready port.
module hash_msg_sender #(
  parameter int LEN_W   = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  hash_msg_sender_if.master  bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    GAP   = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  idx;
  logic [WAIT_W-1:0] wcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      wcnt            <= '0;
      bus.s_ready     <= 1'b0;
      bus.M_valid     <= 1'b0;
      bus.message     <= '0;
      bus.counter     <= '0;
      bus.d_valid     <= 1'b0;
      bus.d_data      <= '0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.counter     <= bus.msg_len;
            idx             <= '0;
            bus.timeout_err <= 1'b0;
            bus.busy        <= 1'b1;
            // Zero-length message still needs one strobe so the core emits its empty digest
            if (bus.msg_len == '0) begin
              bus.M_valid <= 1'b1;
              state       <= SEND;
            end else begin
              bus.s_ready <= 1'b1;
              state       <= FETCH;
            end
          end
        end

        FETCH: begin
          if (bus.s_valid) begin
            bus.message <= bus.s_data;
            bus.s_ready <= 1'b0;
            bus.M_valid <= 1'b1;
            state       <= SEND;
          end
        end

        SEND: begin
          bus.M_valid <= 1'b0;
          if (bus.counter != '0) idx <= idx + LEN_W'(1);
          state <= GAP;
        end

        // hash_ready from the core lags M_valid by a cycle, so it is not trusted here
        GAP: begin
          wcnt  <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (bus.hash_ready) begin
            if (idx == bus.counter) begin
              bus.d_data  <= bus.digest_in;
              bus.d_valid <= 1'b1;
              state       <= DONE;
            end else begin
              bus.s_ready <= 1'b1;
              state       <= FETCH;
            end
          end else if (wcnt == WAIT_W'(TIMEOUT - 1)) begin
            bus.timeout_err <= 1'b1;
            bus.d_data      <= '0;
            bus.busy        <= 1'b0;
            state           <= IDLE;
          end else begin
            wcnt <= wcnt + WAIT_W'(1);
          end
        end

        DONE: begin
          if (bus.d_ready) begin
            bus.d_valid <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_msg_sender.sv
// Directed-plus-random bench for hash_msg_sender with a cycle model of the hash core.
module tb_hash_msg_sender;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hash_msg_sender_if #(.LEN_W(64)) bus();

  hash_msg_sender #(.LEN_W(64), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Stand-in hash: the two published reference digests, otherwise an FNV-style fold.
  function automatic logic [31:0] ref_digest(input byte_q_t q);
    logic [31:0] h;
    if (q.size() == 0) return 32'h956F7883;
    if (q.size() == 1 && q[0] == 8'h41) return 32'h2dd99066;
    h = 32'h811C9DC5;
    foreach (q[i]) h = (h ^ {24'h0, q[i]}) * 32'h01000193;
    return h ^ 32'(q.size());
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hash core model
  byte_q_t     rx_q;
  int          mv_cnt  = 0;
  logic        cnt_bad = 1'b0;
  logic        mv_dbl  = 1'b0;
  logic        prev_mv = 1'b0;
  int          bsy     = 0;
  bit          stuck   = 1'b0;
  logic [63:0] exp_len = '0;

  always @(posedge clk) begin
    prev_mv <= bus.M_valid;
    if (rst) begin
      bus.hash_ready <= 1'b1;
      bus.digest_in  <= '0;
      bsy            <= 0;
    end else if (bus.M_valid === 1'b1) begin
      mv_cnt <= mv_cnt + 1;
      if (prev_mv === 1'b1) mv_dbl <= 1'b1;
      if (bus.counter !== exp_len) cnt_bad <= 1'b1;
      if (bus.counter != 0) rx_q.push_back(bus.message);
      bus.hash_ready <= 1'b0;
      bsy            <= int'($urandom_range(0, 3));
    end else if (!bus.hash_ready && !stuck) begin
      if (bsy == 0) begin
        bus.hash_ready <= 1'b1;
        bus.digest_in  <= ref_digest(rx_q);
      end else begin
        bsy <= bsy - 1;
      end
    end
  end

  function automatic int pick_gap(input int fixed, input int j, input int maxgap);
    if (fixed != 0) return (j == 0) ? 0 : (j == 1) ? 2 : 5;
    return int'($urandom_range(0, maxgap));
  endfunction

  task automatic run_msg(input byte_q_t b, input int maxgap, input int fixed,
                         input int dhold, input int poke, output logic [31:0] dd);
    int len, idx, gap, cyc, dwait, mv0, exp_mv;
    bit got, hs, acc, sr_bad, rx_ok;
    logic [31:0] exp_d;
    len    = b.size();
    exp_d  = ref_digest(b);
    exp_mv = (len == 0) ? 1 : len;
    rx_q.delete();
    exp_len = 64'(len);
    mv0 = mv_cnt;
    idx = 0; cyc = 0; dwait = 0; got = 0; sr_bad = 0; dd = '0;
    gap = pick_gap(fixed, 0, maxgap);
    bus.start   = 1'b1;
    bus.msg_len = 64'(len);
    while (!got && cyc < 400) begin
      bus.s_valid = (idx < len && gap == 0);
      bus.s_data  = (idx < len) ? b[idx] : 8'h00;
      bus.d_ready = bus.d_valid && (dwait >= dhold);
      if (bus.s_ready && idx >= len) sr_bad = 1'b1;
      if (bus.d_valid) begin
        chk("d_data_hold", 64'(bus.d_data), 64'(exp_d));
        dd = bus.d_data;
        dwait++;
      end
      hs  = bus.s_valid && bus.s_ready;
      acc = bus.d_valid && bus.d_ready;
      @(posedge clk); #1;
      cyc++;
      bus.start = (poke != 0 && cyc == 3);
      if (bus.start) bus.msg_len = 64'(len + 7);
      if (hs) begin
        idx++;
        gap = pick_gap(fixed, idx, maxgap);
      end else if (!bus.s_valid && gap > 0) begin
        gap--;
      end
      if (acc) got = 1'b1;
    end
    bus.s_valid = 1'b0;
    bus.d_ready = 1'b0;
    bus.start   = 1'b0;
    rx_ok = (rx_q.size() == b.size());
    foreach (b[i]) if (rx_ok && rx_q[i] !== b[i]) rx_ok = 1'b0;
    chk("result_accepted", 64'(got), 64'(1));
    chk("bytes_consumed", 64'(idx), 64'(len));
    chk("s_ready_excess", 64'(sr_bad), 64'(0));
    chk("m_valid_pulses", 64'(mv_cnt - mv0), 64'(exp_mv));
    chk("counter_on_strobe", 64'(cnt_bad), 64'(0));
    chk("m_valid_one_cycle", 64'(mv_dbl), 64'(0));
    chk("core_bytes", 64'(rx_ok), 64'(1));
    chk("busy_after", 64'(bus.busy), 64'(0));
    chk("d_valid_after", 64'(bus.d_valid), 64'(0));
    chk("timeout_err_clear", 64'(bus.timeout_err), 64'(0));
    chk("counter_len", bus.counter, 64'(len));
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_M_valid"}, 64'(bus.M_valid), 64'(0));
    chk({pfx, "_message"}, 64'(bus.message), 64'(0));
    chk({pfx, "_counter"}, bus.counter, 64'(0));
    chk({pfx, "_s_ready"}, 64'(bus.s_ready), 64'(0));
    chk({pfx, "_d_valid"}, 64'(bus.d_valid), 64'(0));
    chk({pfx, "_d_data"}, 64'(bus.d_data), 64'(0));
    chk({pfx, "_busy"}, 64'(bus.busy), 64'(0));
    chk({pfx, "_timeout_err"}, 64'(bus.timeout_err), 64'(0));
  endtask

  initial begin
    byte_q_t     q;
    logic [31:0] dd;
    int          k, mvs;
    bit          seen, dv_seen;

    bus.start = 1'b0; bus.msg_len = '0; bus.s_valid = 1'b0;
    bus.s_data = '0; bus.d_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-length message
    q = {};
    run_msg(q, 0, 0, 0, 0, dd);
    chk("empty_digest", 64'(dd), 64'(32'h956F7883));

    // Single byte "A"
    q = {8'h41};
    run_msg(q, 0, 0, 0, 0, dd);
    chk("A_digest", 64'(dd), 64'(32'h2dd99066));

    // Three bytes, upstream gaps 0/2/5, downstream holds off 4 cycles
    q = {};
    repeat (3) q.push_back(8'($urandom));
    run_msg(q, 0, 1, 4, 0, dd);

    // Randomized messages, some with a start pulse while busy
    for (int i = 0; i < 8; i++) begin
      q = {};
      repeat (int'($urandom_range(1, 6))) q.push_back(8'($urandom));
      run_msg(q, int'($urandom_range(0, 3)), 0, int'($urandom_range(0, 3)), (i % 3 == 1) ? 1 : 0, dd);
      chk("rand_digest", 64'(dd), 64'(ref_digest(q)));
    end

    // Core never returns hash_ready: abort after 16 WAIT cycles
    stuck = 1'b1;
    exp_len = 64'd2;
    rx_q.delete();
    mvs = mv_cnt;
    bus.start = 1'b1; bus.msg_len = 64'd2;
    bus.s_valid = 1'b1; bus.s_data = 8'($urandom);
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.M_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    bus.s_valid = 1'b0;
    chk("to_first_strobe", 64'(seen), 64'(1));
    k = 0; dv_seen = 1'b0;
    while (!bus.timeout_err && k < 100) begin
      if (bus.d_valid) dv_seen = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    chk("to_latency", 64'(k), 64'(18));
    chk("to_err_set", 64'(bus.timeout_err), 64'(1));
    chk("to_busy", 64'(bus.busy), 64'(0));
    chk("to_no_d_valid", 64'(dv_seen | bus.d_valid), 64'(0));
    chk("to_pulses", 64'(mv_cnt - mvs), 64'(1));
    chk("to_d_data", 64'(bus.d_data), 64'(0));
    stuck = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    q = {};
    repeat (2) q.push_back(8'($urandom));
    run_msg(q, 1, 0, 1, 0, dd);
    chk("after_to_digest", 64'(dd), 64'(ref_digest(q)));

    // Reset while waiting on the core mid 3-byte message
    stuck = 1'b1;
    exp_len = 64'd3;
    rx_q.delete();
    bus.start = 1'b1; bus.msg_len = 64'd3;
    bus.s_valid = 1'b1; bus.s_data = 8'hA5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.M_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    bus.s_valid = 1'b0;
    chk("rst_first_strobe", 64'(seen), 64'(1));
    repeat (4) @(posedge clk);
    #1;
    chk("rst_pre_busy", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("midrst");
    stuck = 1'b0;
    mvs = mv_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_strobe", 64'(mv_cnt - mvs), 64'(0));
    q = {8'h41};
    run_msg(q, 0, 0, 0, 0, dd);
    chk("rst_A_digest", 64'(dd), 64'(32'h2dd99066));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
